// File: rtl/pulse_pkg.sv
// Shared types, constants and small arithmetic helpers for the readout
// pulse generator and its sine/cosine table.
package pulse_pkg;

    localparam int LANES     = 5;
    localparam int LUT_DEPTH = 50;
    localparam int DW        = 16;
    localparam int PHW       = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    typedef logic signed [DW-1:0] sample_t;
    typedef sample_t lane_arr_t [LANES];

    // (p + jf) mod 50 for p <= 49 and jf <= 60: two conditional subtractions suffice.
    function automatic logic [PHW-1:0] mod50_add(input logic [PHW-1:0] p, input logic [5:0] jf);
        logic [6:0] s;
        s = {1'b0, p} + {1'b0, jf};
        if (s >= 7'd50) s = s - 7'd50;
        if (s >= 7'd50) s = s - 7'd50;
        return PHW'(s);
    endfunction

    function automatic logic [PHW-1:0] step_of(input logic [3:0] f);
        logic [6:0] s;
        s = {1'b0, f, 2'b00} + {3'b000, f};
        if (s >= 7'd50) s = s - 7'd50;
        return PHW'(s);
    endfunction

    function automatic logic [LANES*DW-1:0] pack_lanes(input lane_arr_t a);
        logic [LANES*DW-1:0] r;
        for (int j = 0; j < LANES; j++) r[j*DW +: DW] = a[j];
        return r;
    endfunction

    function automatic sample_t lane_get(input logic [LANES*DW-1:0] v, input int j);
        return v[j*DW +: DW];
    endfunction

endpackage

// File: rtl/readout_pulse_gen_lut.sv
// Registered multi-port Q1.15 cos/sin ROM over 50 phase points; shared with
// the receive-side mixer.
module iq_sincos_lut
    import pulse_pkg::*;
(
    input  logic           clk_100,
    input  logic [PHW-1:0] idx_i [LANES],
    output lane_arr_t      cos_o,
    output lane_arr_t      sin_o
);

    // round(32767*cos(m*3.6 deg)), m = 0..25; the full period folds onto this.
    localparam sample_t QCOS [26] = '{
        16'sd32767, 16'sd32702, 16'sd32509, 16'sd32187, 16'sd31738, 16'sd31163,
        16'sd30466, 16'sd29648, 16'sd28714, 16'sd27666, 16'sd26509, 16'sd25247,
        16'sd23886, 16'sd22431, 16'sd20886, 16'sd19260, 16'sd17557, 16'sd15786,
        16'sd13952, 16'sd12062, 16'sd10126, 16'sd8149,  16'sd6140,  16'sd4107,
        16'sd2057,  16'sd0
    };

    function automatic sample_t cos_at(input logic [PHW-1:0] k);
        logic [PHW-1:0] kk;
        sample_t v;
        kk = (k > 6'd25) ? 6'd50 - k : k;
        if (k >= 6'd50)       v = '0;
        else if (kk <= 6'd12) v = QCOS[5'(kk << 1)];
        else                  v = -QCOS[5'(6'd50 - (kk << 1))];
        return v;
    endfunction

    function automatic sample_t sin_at(input logic [PHW-1:0] k);
        logic [PHW-1:0] kk;
        sample_t v;
        kk = (k > 6'd25) ? 6'd50 - k : k;
        if (k >= 6'd50)       v = '0;
        else if (kk <= 6'd12) v = QCOS[5'(6'd25 - (kk << 1))];
        else                  v = QCOS[5'((kk << 1) - 6'd25)];
        return (k > 6'd25) ? -v : v;
    endfunction

    always_ff @(posedge clk_100) begin
        for (int j = 0; j < LANES; j++) begin
            cos_o[j] <= cos_at(idx_i[j]);
            sin_o[j] <= sin_at(idx_i[j]);
        end
    end

endmodule

// File: rtl/readout_pulse_gen.sv
// Five-lane I/Q readout tone generator: phase stage, registered LUT stage,
// amplitude-scaling stage, wrapped in an IDLE/RUN/FLUSH sequencer.
module readout_pulse_gen
    import pulse_pkg::*;
(
    input  logic                clk_100,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [3:0]          demod_freq,
    input  logic [10:0]         pulse_length,
    input  logic [14:0]         amp,
    output logic [LANES*DW-1:0] dac_i,
    output logic [LANES*DW-1:0] dac_q,
    output logic                dac_valid,
    output logic                marker,
    output logic                busy,
    output logic                done
);

    state_t              state_q;
    logic [3:0]          freq_q;
    logic [10:0]         len_q, cnt_q;
    logic [14:0]         amp_q;
    logic [PHW-1:0]      step_q, p_q;
    logic [PHW-1:0]      ph_q [LANES];
    logic [PHW-1:0]      ph_d [LANES];
    logic                v1_q, v2_q, m1_q, m2_q;
    logic [LANES*DW-1:0] dac_i_q, dac_q_q;
    logic                valid_q, marker_q, busy_q, done_q;

    logic [PHW-1:0]      p_src;
    logic [3:0]          f_src;
    lane_arr_t           cos_w, sin_w, lane_i, lane_q;
    logic signed [2*DW-1:0] prod_i [LANES];
    logic signed [2*DW-1:0] prod_q [LANES];
    logic signed [DW-1:0]   amp_s;

    // The first phase word is issued on the accepting edge from the raw inputs,
    // which is what gives the three-cycle start-to-valid latency.
    assign p_src = (state_q == ST_IDLE) ? '0 : p_q;
    assign f_src = (state_q == ST_IDLE) ? demod_freq : freq_q;
    assign amp_s = $signed({1'b0, amp_q});

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        localparam logic [5:0] JW = 6'(gi);
        assign ph_d[gi]   = mod50_add(p_src, JW * {2'b00, f_src});
        assign prod_i[gi] = amp_s * cos_w[gi];
        assign prod_q[gi] = amp_s * sin_w[gi];
        assign lane_i[gi] = DW'(prod_i[gi] >>> 15);
        assign lane_q[gi] = DW'(prod_q[gi] >>> 15);
    end

    iq_sincos_lut u_lut (
        .clk_100 (clk_100),
        .idx_i   (ph_q),
        .cos_o   (cos_w),
        .sin_o   (sin_w)
    );

    always_ff @(posedge clk_100) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            freq_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            amp_q    <= '0;
            step_q   <= '0;
            p_q      <= '0;
            ph_q     <= '{default: '0};
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            m1_q     <= 1'b0;
            m2_q     <= 1'b0;
            dac_i_q  <= '0;
            dac_q_q  <= '0;
            valid_q  <= 1'b0;
            marker_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            v1_q     <= 1'b0;
            m1_q     <= 1'b0;
            v2_q     <= v1_q;
            m2_q     <= m1_q;
            valid_q  <= v2_q;
            marker_q <= m2_q;
            dac_i_q  <= v2_q ? pack_lanes(lane_i) : '0;
            dac_q_q  <= v2_q ? pack_lanes(lane_q) : '0;
            done_q   <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (start && pulse_length != 11'd0) begin
                        freq_q  <= demod_freq;
                        len_q   <= pulse_length;
                        amp_q   <= amp;
                        step_q  <= step_of(demod_freq);
                        p_q     <= step_of(demod_freq);
                        ph_q    <= ph_d;
                        cnt_q   <= 11'd1;
                        v1_q    <= 1'b1;
                        m1_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN, ST_FLUSH: begin
                    if (state_q == ST_FLUSH && done_q) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (abort) begin
                        v2_q     <= 1'b0;
                        m2_q     <= 1'b0;
                        valid_q  <= 1'b0;
                        marker_q <= 1'b0;
                        dac_i_q  <= '0;
                        dac_q_q  <= '0;
                        done_q   <= 1'b1;
                        state_q  <= ST_FLUSH;
                    end else if (state_q == ST_FLUSH) begin
                        if (!v1_q && !v2_q) done_q <= 1'b1;
                    end else if (cnt_q == len_q) begin
                        state_q <= ST_FLUSH;
                    end else begin
                        ph_q  <= ph_d;
                        p_q   <= mod50_add(p_q, step_q);
                        cnt_q <= cnt_q + 11'd1;
                        v1_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dac_i     = dac_i_q;
    assign dac_q     = dac_q_q;
    assign dac_valid = valid_q;
    assign marker    = marker_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
